// File: rtl/reg_dest_pipe_pkg.sv
// Shared constants for destination-register selection: register-0 encoding,
// candidate source indices and the select-width helper.
package reg_dest_pipe_pkg;

   localparam int AW_DEF = 3;
   localparam logic [AW_DEF-1:0] REG_ZERO = '0;

   localparam int SRC_RT = 0;
   localparam int SRC_RD = 1;
   localparam int SRC_RA = 2;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_dest_stage.sv
// One pipeline slot holding {valid, addr}; a bubble load clears both.
module reg_dest_stage #(
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_bubble,
   input  logic          i_vld,
   input  logic [AW-1:0] i_addr,
   output logic          o_vld,
   output logic [AW-1:0] o_addr
);

   logic          r_vld;
   logic [AW-1:0] r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_addr <= '0;
      end else if (i_bubble) begin
         r_vld  <= 1'b0;
         r_addr <= '0;
      end else begin
         r_vld  <= i_vld;
         r_addr <= i_addr;
      end
   end

   assign o_vld  = r_vld;
   assign o_addr = r_addr;

endmodule

// File: rtl/reg_dest_pipe.sv
// Destination-register selector at decode plus a DEPTH-stage tracker of the
// chosen address, driving the register-file write port and hazard matches.
module reg_dest_pipe
   import reg_dest_pipe_pkg::*;
#(
   parameter  int AW       = AW_DEF,
   parameter  int NUM_SRC  = 3,
   parameter  int DEPTH    = 3,
   parameter  int ZERO_SUP = 1,
   localparam int SEL_W    = sel_width(NUM_SRC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC*AW-1:0] src_addr,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  wr_en_in,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [AW-1:0]         rs_addr,
   input  logic [AW-1:0]         rt_addr,
   output logic [DEPTH*AW-1:0]   stage_addr,
   output logic [DEPTH-1:0]      stage_vld,
   output logic [DEPTH-1:0]      rs_hit,
   output logic [DEPTH-1:0]      rt_hit,
   output logic [AW-1:0]         wb_addr,
   output logic                  wb_en,
   output logic                  sel_err
);

   localparam bit ZS = (ZERO_SUP != 0);

   logic [AW-1:0] w_cand [NUM_SRC];
   logic [AW-1:0] w_d_addr;
   logic          w_sel_ok;
   logic          w_d_vld;
   logic          w_rs_ok;
   logic          w_rt_ok;
   logic          r_sel_err;

   logic          w_stg_vld  [DEPTH];
   logic [AW-1:0] w_stg_addr [DEPTH];
   logic          w_in_vld   [DEPTH];
   logic [AW-1:0] w_in_addr  [DEPTH];
   logic          w_bubble   [DEPTH];

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_cand
      assign w_cand[k] = src_addr[k*AW +: AW];
   end

   // An out-of-range select matches no candidate, leaving address 0 and not-ok.
   always_comb begin
      w_d_addr = '0;
      w_sel_ok = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            w_d_addr = w_cand[k];
            w_sel_ok = 1'b1;
         end
      end
   end

   assign w_d_vld = wr_en_in & w_sel_ok & ~(ZS & (w_d_addr == AW'(REG_ZERO)));
   assign w_rs_ok = ~(ZS & (rs_addr == AW'(REG_ZERO)));
   assign w_rt_ok = ~(ZS & (rt_addr == AW'(REG_ZERO)));

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign w_in_vld[g]  = w_d_vld;
         assign w_in_addr[g] = w_d_addr;
         assign w_bubble[g]  = flush | stall;
      end else if (g == 1) begin : g_squash
         // Flush also kills the instruction that was in stage 0.
         assign w_in_vld[g]  = w_stg_vld[g-1];
         assign w_in_addr[g] = w_stg_addr[g-1];
         assign w_bubble[g]  = flush;
      end else begin : g_shift
         assign w_in_vld[g]  = w_stg_vld[g-1];
         assign w_in_addr[g] = w_stg_addr[g-1];
         assign w_bubble[g]  = 1'b0;
      end

      reg_dest_stage #(.AW(AW)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_bubble (w_bubble[g]),
         .i_vld    (w_in_vld[g]),
         .i_addr   (w_in_addr[g]),
         .o_vld    (w_stg_vld[g]),
         .o_addr   (w_stg_addr[g])
      );

      assign stage_addr[g*AW +: AW] = w_stg_addr[g];
      assign stage_vld[g]           = w_stg_vld[g];
      assign rs_hit[g] = w_stg_vld[g] & (w_stg_addr[g] == rs_addr) & w_rs_ok;
      assign rt_hit[g] = w_stg_vld[g] & (w_stg_addr[g] == rt_addr) & w_rt_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sel_err <= 1'b0;
      else        r_sel_err <= wr_en_in & ~w_sel_ok & ~flush & ~stall;
   end

   assign sel_err = r_sel_err;
   assign wb_addr = w_stg_addr[DEPTH-1];
   assign wb_en   = w_stg_vld[DEPTH-1];

endmodule
